mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// - CPU-side MAR/MDR unit upstream of the RAM: holds MAR/MDR, sequences read/write strobes, waits on RAM ready (R).
// - Decodes memory-mapped display registers (DSR/DDR) locally so TRAP output needs no RAM access.
// - Reports completion (done/err) to the control FSM; only one access in flight.
// PARAMETERS
// - DATA_W      16       address and data width
// - DSR_ADDR    16'hFE04 display status register address (read-only)
// - DDR_ADDR    16'hFE06 display data register address (write-only)
// - TIMEOUT_CYC 64       max cycles waiting on R per phase (TIMEOUT_EN only)
// PORTS
// - clock      in  1      system clock, rising edge
// - reset_n    in  1      asynchronous, active-low reset
// - bus_in     in  DATA_W datapath bus value for MAR/MDR loads
// - ld_mar     in  1      load MAR from bus_in (idle only)
// - ld_mdr     in  1      load MDR from bus_in (idle only)
// - mem_req    in  1      start access (one-cycle pulse, idle only)
// - mem_we     in  1      sampled with mem_req: 1=write MDR to [MAR], 0=read [MAR] into MDR
// - mdr_q      out DATA_W current MDR (to datapath gate)
// - busy       out 1      access in progress
// - done       out 1      one-cycle pulse: access finished
// - err        out 1      one-cycle pulse with done: access timed out
// - mem_addr   out DATA_W MAR to RAM
// - mem_wdata  out DATA_W MDR to RAM
// - mem_read   out 1      RAM read strobe
// - mem_write  out 1      RAM write strobe
// - mem_rdata  in  DATA_W RAM read data
// - mem_r      in  1      RAM ready
// - ddr_data   out DATA_W display character
// - ddr_valid  out 1      one-cycle pulse: ddr_data written
// - disp_ack   in  1      display consumed character; sets ready
// BEHAVIOUR
// - Reset (async): MAR=MDR=0, ddr_data=0, all strobes/pulses/busy=0, ddr_ready=1, state IDLE, counter 0.
// - ld_mar/ld_mdr honoured only in IDLE; ignored while busy. Same-cycle ld_* with mem_req: loads take effect, access uses new values.
// - States: IDLE, DECODE, ACCESS, RELEASE, FINISH.
// - IDLE: mem_req -> latch mem_we, busy=1, go DECODE.
// - DECODE: MAR==DDR_ADDR & write -> ddr_data<=MDR, ddr_valid=1 for one cycle, ddr_ready<=0, go FINISH.
//   MAR==DSR_ADDR & read -> MDR<={ddr_ready,15'b0}, go FINISH. DDR read / DSR write -> no effect, go FINISH.
//   Otherwise assert mem_read or mem_write, go ACCESS.
// - ACCESS: hold strobe and mem_addr/mem_wdata stable until mem_r=1; on that edge read captures mem_rdata into MDR, strobe drops, go RELEASE.
// - RELEASE: wait mem_r=0 (RAM holds R several cycles), then go FINISH. Prevents a new access seeing stale R.
// - FINISH: done=1, busy=0 next, go IDLE.
// - Minimum latency mem_req->done: I/O 2 cycles; RAM 4 cycles (mem_r high 1 cycle, low the next).
// - mem_req while busy ignored. mem_r high in IDLE/DECODE ignored.
// - disp_ack sets ddr_ready=1; same-cycle DDR write wins (ready=0).
// - reset_n low mid-access: strobes drop immediately, no done, MDR cleared.
// CONFIGURATION
// - MEM_TIMEOUT_EN defined: cycle counter cleared on entering ACCESS and RELEASE; reaching TIMEOUT_CYC -> strobes drop, MDR unchanged, FINISH with done=1 and err=1.
// - MEM_TIMEOUT_EN undefined: waits indefinitely on mem_r; err tied 0, no counter logic.
// TESTING
// - ld_mar x3000, mem_req read, RAM returns x5020 with mem_r 1 cycle later -> mdr_q=x5020, done 4 cycles after req, err=0.
// - ld_mar x3020, ld_mdr xBEEF, write, mem_r held 5 cycles -> mem_write drops on first mem_r, done only after mem_r falls.
// - MAR=xFE06, MDR=x0041, write -> ddr_valid 1 cycle, ddr_data=x0041, no mem strobe; DSR read -> mdr_q=x0000; after disp_ack -> x8000.
// - mem_req and ld_mar x1234 while busy -> ignored, MAR unchanged, single done.
// - MEM_TIMEOUT_EN, TIMEOUT_CYC=8, mem_r never rises -> done+err at cycle 8 of ACCESS, MDR unchanged, next access works.
// - reset_n pulsed low during ACCESS -> mem_read=0 asynchronously, all outputs reset, no done.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// CPU-side MAR/MDR unit that sits in front of the RAM. It holds MAR and MDR,
// sequences the RAM read/write strobes, and waits on the RAM ready (mem_r)
// handshake. It also decodes the memory-mapped display registers (DSR/DDR)
// locally, so those accesses never reach the RAM. Completion is reported to
// the control FSM with a one-cycle done pulse. Only one access is in flight
// at a time.
//
// Optional feature: define MEM_TIMEOUT_EN to bound every wait on mem_r to
// TIMEOUT_CYC cycles per phase. A timed-out access ends with done=1 and
// err=1. Without the macro the unit waits indefinitely, err is tied 0 and
// no counter exists.
//
// Ports
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   bus_in           datapath value for MAR/MDR loads
//   ld_mar, ld_mdr   load MAR/MDR from bus_in (honoured only while idle)
//   mem_req, mem_we  start an access (pulse, idle only); 1=write, 0=read
//   mdr_q            current MDR contents
//   busy, done, err  access in progress / finished pulse / timed-out pulse
//   mem_addr, mem_wdata, mem_read, mem_write, mem_rdata, mem_r   RAM side
//   ddr_data, ddr_valid   display character and its one-cycle write pulse
//   disp_ack         display consumed the character (sets DSR ready)
module mem_access_ctrl #(
  parameter int unsigned       DATA_W      = 16,
  parameter logic [DATA_W-1:0] DSR_ADDR    = 16'hFE04,
  parameter logic [DATA_W-1:0] DDR_ADDR    = 16'hFE06,
  parameter int unsigned       TIMEOUT_CYC = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              mem_req,
  input  logic              mem_we,
  output logic [DATA_W-1:0] mdr_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_r,
  output logic [DATA_W-1:0] ddr_data,
  output logic              ddr_valid,
  input  logic              disp_ack
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [DATA_W-1:0]   ddr_data_q, ddr_data_d;
  logic                ddr_valid_q, ddr_valid_d;
  logic                ddr_ready_q, ddr_ready_d;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 32'd1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
`else
  // Keeps the parameter referenced in the build without the timeout.
  logic [31:0]         unused_timeout_s;
  assign unused_timeout_s = TIMEOUT_CYC;
`endif

  // Next-state, datapath and strobe computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    mar_d       = mar_q;
    mdr_d       = mdr_q;
    we_d        = we_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    ddr_data_d  = ddr_data_q;
    ddr_valid_d = 1'b0;
    // A DDR write in DECODE below overrides this (write wins over ack).
    if (disp_ack) begin
      ddr_ready_d = 1'b1;
    end else begin
      ddr_ready_d = ddr_ready_q;
    end
`ifdef MEM_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ld_mar) begin
          mar_d = bus_in;
        end else begin
          mar_d = mar_q;
        end
        if (ld_mdr) begin
          mdr_d = bus_in;
        end else begin
          mdr_d = mdr_q;
        end
        if (mem_req) begin
          we_d    = mem_we;
          busy_d  = 1'b1;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DECODE: begin
        if (mar_q == DDR_ADDR) begin
          // DDR is write-only: a read of it completes with no effect.
          if (we_q) begin
            ddr_data_d  = mdr_q;
            ddr_valid_d = 1'b1;
            ddr_ready_d = 1'b0;
          end else begin
            ddr_valid_d = 1'b0;
          end
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end else if (mar_q == DSR_ADDR) begin
          // DSR is read-only: a write to it completes with no effect.
          if (!we_q) begin
            mdr_d = {ddr_ready_q, {(DATA_W-1){1'b0}}};
          end else begin
            mdr_d = mdr_q;
          end
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          mem_read_d  = ~we_q;
          mem_write_d = we_q;
          state_d     = ST_ACCESS;
`ifdef MEM_TIMEOUT_EN
          cnt_d = {CNT_W{1'b0}};
`endif
        end
      end

      ST_ACCESS: begin
        if (mem_r) begin
          if (!we_q) begin
            mdr_d = mem_rdata;
          end else begin
            mdr_d = mdr_q;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = ST_RELEASE;
`ifdef MEM_TIMEOUT_EN
          cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          done_d      = 1'b1;
          err_d       = 1'b1;
          state_d     = ST_FINISH;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`else
        end else begin
          state_d = ST_ACCESS;
`endif
        end
      end

      ST_RELEASE: begin
        // RAM keeps R high for several cycles; wait it out so the next
        // access cannot complete on a stale ready.
        if (!mem_r) begin
          done_d  = 1'b1;
          state_d = ST_FINISH;
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`else
        end else begin
          state_d = ST_RELEASE;
`endif
        end
      end

      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d      = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; all outputs come straight from these.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mar_q       <= {DATA_W{1'b0}};
      mdr_q       <= {DATA_W{1'b0}};
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      ddr_data_q  <= {DATA_W{1'b0}};
      ddr_valid_q <= 1'b0;
      ddr_ready_q <= 1'b1;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= {CNT_W{1'b0}};
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      ddr_data_q  <= ddr_data_d;
      ddr_valid_q <= ddr_valid_d;
      ddr_ready_q <= ddr_ready_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign ddr_data  = ddr_data_q;
  assign ddr_valid = ddr_valid_q;
`ifdef MEM_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. A transaction-level model keeps
// the expected MAR, MDR, display data and display-ready flag, and predicts
// strobe windows and done latency from the RAM handshake timing chosen for
// each access.
module tb_mem_access_ctrl;
  localparam int          DW  = 16;
  localparam int          TO  = 8;
  localparam logic [15:0] DSR = 16'hFE04;
  localparam logic [15:0] DDR = 16'hFE06;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [DW-1:0] bus_in;
  logic          ld_mar, ld_mdr, mem_req, mem_we;
  logic [DW-1:0] mdr_q;
  logic          busy, done, err;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_rdata;
  logic          mem_r;
  logic [DW-1:0] ddr_data;
  logic          ddr_valid, disp_ack;

  always #5 clock = ~clock;

  mem_access_ctrl #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset_n(reset_n), .bus_in(bus_in), .ld_mar(ld_mar),
    .ld_mdr(ld_mdr), .mem_req(mem_req), .mem_we(mem_we), .mdr_q(mdr_q),
    .busy(busy), .done(done), .err(err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_r(mem_r), .ddr_data(ddr_data),
    .ddr_valid(ddr_valid), .disp_ack(disp_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [15:0] exp_mar, exp_mdr, exp_ddr_data;
  logic        exp_ready;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic load(input logic lm, input logic ld, input logic [15:0] v);
    bus_in = v; ld_mar = lm; ld_mdr = ld;
    tick();
    ld_mar = 1'b0; ld_mdr = 1'b0;
    if (lm) exp_mar = v;
    if (ld) exp_mdr = v;
    chk("mar_load", mem_addr, exp_mar);
    chk("mdr_load", mdr_q, exp_mdr);
  endtask

  task automatic ack();
    disp_ack = 1'b1;
    tick();
    disp_ack  = 1'b0;
    exp_ready = 1'b1;
  endtask

  // One access with RAM ready rising 'delay' cycles after the strobe and
  // staying high 'hold' cycles. poke: extra req/ld_mar while busy.
  // same_ld: load MAR with ld_val in the same cycle as mem_req.
  task automatic access(input logic we, input logic [15:0] rdata, input int delay,
                        input int hold, input logic poke, input logic expect_to,
                        input logic same_ld, input logic [15:0] ld_val);
    logic io;
    logic is_ddr_wr;
    logic got_done;
    int   lat;
    int   strobe_end;
    logic exp_strobe;
    mem_we = we; mem_req = 1'b1; mem_rdata = rdata;
    if (same_ld) begin
      ld_mar = 1'b1; bus_in = ld_val; exp_mar = ld_val;
    end
    io        = (exp_mar == DSR) || (exp_mar == DDR);
    is_ddr_wr = (exp_mar == DDR) && we;
    if (io) lat = 2;
    else if (expect_to) lat = 2 + TO;
    else lat = 3 + delay + hold;
    strobe_end = expect_to ? 2 + TO : 3 + delay;
    tick();
    mem_req = 1'b0; ld_mar = 1'b0;
    got_done = 1'b0;
    for (int t = 1; t <= 60 && !got_done; t++) begin
      mem_r = !io && (t >= 2 + delay) && (t < 2 + delay + hold);
      if (poke && t == 3) begin
        mem_req = 1'b1; ld_mar = 1'b1; bus_in = 16'h1234; mem_we = ~we;
      end else begin
        mem_req = 1'b0; ld_mar = 1'b0;
      end
      exp_strobe = !io && (t >= 2) && (t < strobe_end);
      chk("mem_read", mem_read, exp_strobe && !we);
      chk("mem_write", mem_write, exp_strobe && we);
      if (exp_strobe) chk("mem_addr", mem_addr, exp_mar);
      if (exp_strobe && we) chk("mem_wdata", mem_wdata, exp_mdr);
      chk("ddr_valid", ddr_valid, is_ddr_wr && (t == 2));
      chk("done", done, t == lat);
      if (t == lat) begin
        got_done = 1'b1;
        chk("err", err, expect_to);
        chk("busy_at_done", busy, 1'b1);
      end else begin
        tick();
      end
    end
    mem_r = 1'b0; mem_req = 1'b0; ld_mar = 1'b0;
    if (!got_done) chk("done_timeout", 32'd0, 32'd1);
    // Model update for the completed access.
    if (exp_mar == DDR) begin
      if (we) begin exp_ddr_data = exp_mdr; exp_ready = 1'b0; end
    end else if (exp_mar == DSR) begin
      if (!we) exp_mdr = {exp_ready, 15'b0};
    end else if (!we && !expect_to) begin
      exp_mdr = rdata;
    end
    chk("mdr_after", mdr_q, exp_mdr);
    chk("ddr_data", ddr_data, exp_ddr_data);
    tick();
    chk("busy_after", busy, 1'b0);
    chk("done_once", done, 1'b0);
    chk("mar_after", mem_addr, exp_mar);
  endtask

  initial begin
    reset_n = 1'b0; bus_in = 16'h0; ld_mar = 1'b0; ld_mdr = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_rdata = 16'h0; mem_r = 1'b0;
    disp_ack = 1'b0;
    exp_mar = 16'h0; exp_mdr = 16'h0; exp_ddr_data = 16'h0; exp_ready = 1'b1;
    #23;
    chk("rst_mdr", mdr_q, 16'h0);
    chk("rst_addr", mem_addr, 16'h0);
    chk("rst_flags", {busy, done, err, mem_read, mem_write, ddr_valid}, 6'b0);
    chk("rst_ddr", ddr_data, 16'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_flags", {busy, done, err, mem_read, mem_write, ddr_valid}, 6'b0);

    // RAM read, ready one cycle after strobe: done 4 cycles after req.
    load(1'b1, 1'b0, 16'h3000);
    access(1'b0, 16'h5020, 0, 1, 1'b0, 1'b0, 1'b0, 16'h0);
    // RAM write with R held 5 cycles.
    load(1'b1, 1'b0, 16'h3020);
    load(1'b0, 1'b1, 16'hBEEF);
    access(1'b1, 16'h0000, 0, 5, 1'b0, 1'b0, 1'b0, 16'h0);
    // Display: DDR write, DSR read before/after ack.
    load(1'b1, 1'b0, DDR);
    load(1'b0, 1'b1, 16'h0041);
    access(1'b1, 16'h0, 0, 1, 1'b0, 1'b0, 1'b0, 16'h0);
    load(1'b1, 1'b0, DSR);
    access(1'b0, 16'hFFFF, 0, 1, 1'b0, 1'b0, 1'b0, 16'h0);
    ack();
    access(1'b0, 16'hFFFF, 0, 1, 1'b0, 1'b0, 1'b0, 16'h0);
    // ld_mar in the same cycle as mem_req: access uses the new MAR.
    access(1'b0, 16'h7A7A, 1, 2, 1'b0, 1'b0, 1'b1, 16'h2222);
    // req + ld_mar while busy are ignored.
    load(1'b1, 1'b0, 16'h4000);
    access(1'b0, 16'h0BAD, 3, 2, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("no_second_done", {busy, done}, 2'b00);

    // Randomized transactions.
    for (int i = 0; i < 30; i++) begin
      int k;
      k = $urandom_range(0, 5);
      case (k)
        0: begin
          load(1'b1, 1'b0, 16'($urandom_range(0, 16'hFDFF)));
          access(1'b0, 16'($urandom), $urandom_range(0, 3), $urandom_range(1, 4),
                 1'b0, 1'b0, 1'b0, 16'h0);
        end
        1: begin
          load(1'b1, 1'b0, 16'($urandom_range(0, 16'hFDFF)));
          load(1'b0, 1'b1, 16'($urandom));
          access(1'b1, 16'($urandom), $urandom_range(0, 3), $urandom_range(1, 4),
                 1'b0, 1'b0, 1'b0, 16'h0);
        end
        2: begin
          load(1'b1, 1'b0, DDR);
          load(1'b0, 1'b1, 16'($urandom));
          access(1'b1, 16'h0, 0, 1, 1'b0, 1'b0, 1'b0, 16'h0);
        end
        3: begin
          load(1'b1, 1'b0, DSR);
          access(1'b0, 16'($urandom), 0, 1, 1'b0, 1'b0, 1'b0, 16'h0);
        end
        4: begin
          if ($urandom_range(0, 1) == 1) begin
            load(1'b1, 1'b0, DDR);
            access(1'b0, 16'($urandom), 0, 1, 1'b0, 1'b0, 1'b0, 16'h0);
          end else begin
            load(1'b1, 1'b0, DSR);
            access(1'b1, 16'($urandom), 0, 1, 1'b0, 1'b0, 1'b0, 16'h0);
          end
        end
        default: ack();
      endcase
    end

`ifdef MEM_TIMEOUT_EN
    // R never rises: done+err after TO cycles of ACCESS, MDR unchanged.
    load(1'b1, 1'b1, 16'h0100);
    access(1'b0, 16'h9999, 1000, 0, 1'b0, 1'b1, 1'b0, 16'h0);
    access(1'b0, 16'h6666, 0, 1, 1'b0, 1'b0, 1'b0, 16'h0);
`endif

    // Leave display not ready, then reset in the middle of a RAM read.
    load(1'b1, 1'b0, DDR);
    load(1'b0, 1'b1, 16'h0058);
    access(1'b1, 16'h0, 0, 1, 1'b0, 1'b0, 1'b0, 16'h0);
    load(1'b1, 1'b0, 16'h0500);
    mem_we = 1'b0; mem_req = 1'b1;
    tick();
    mem_req = 1'b0;
    tick();
    chk("pre_rst_read", mem_read, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_read", mem_read, 1'b0);
    chk("async_rst_mdr", mdr_q, 16'h0);
    chk("async_rst_flags", {busy, done, ddr_valid}, 3'b000);
    exp_mar = 16'h0; exp_mdr = 16'h0; exp_ddr_data = 16'h0; exp_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_r = (i == 1);
      tick();
      chk("no_done_after_rst", done, 1'b0);
    end
    mem_r = 1'b0;
    chk("rst_ddr_data", ddr_data, 16'h0);
    load(1'b1, 1'b0, DSR);
    access(1'b0, 16'h1111, 0, 1, 1'b0, 1'b0, 1'b0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
